gpr_wb_queue: RTL and testbench
===============================

// Module: gpr_wb_queue
// PURPOSE
//   Write-side driver for the general-purpose register file (GPR) in the multi-cycle CPU.
//   - Accepts writeback requests from the ALU, memory and link sources through a valid/ready handshake.
//   - Buffers requests in a small in-order FIFO.
//   - Drains one entry per enabled cycle onto the GPR write port (rw/wd/regwrite/addi_overflow).
//   - Reports pending-write hazards on two decode read ports (and, optionally, forwards data on them).
// PARAMETERS
//   DEPTH    4   FIFO entries; power of two, >=2
//   CNT_W    3   width of count output; equals log2(DEPTH)+1
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   req_valid      in   1   writeback request valid
//   req_ready      out  1   queue can accept a request this cycle
//   req_rd         in   5   destination register number
//   req_data       in   32  value to write
//   req_ovf        in   1   addi overflow flag; the GPR then writes reg 30 = 1
//   wb_en          in   1   control unit permits a GPR write this cycle (WB state)
//   flush          in   1   discard all pending writes
//   rw             out  5   GPR write register number
//   wd             out  32  GPR write data
//   regwrite       out  1   GPR write enable; one-cycle pulse per entry
//   addi_overflow  out  1   GPR overflow flag, valid together with regwrite
//   chk_rs         in   5   decode read port A register number
//   chk_rt         in   5   decode read port B register number
//   hazard         out  1   chk_rs or chk_rt has a pending write
//   fwd_a_hit      out  1   forwarded value available for chk_rs
//   fwd_a_data     out  32  forwarded value for chk_rs
//   fwd_b_hit      out  1   forwarded value available for chk_rt
//   fwd_b_data     out  32  forwarded value for chk_rt
//   count          out  CNT_W  FIFO occupancy (output stage excluded)
// BEHAVIOUR
//   Reset
//     - All outputs are 0, including req_ready while reset is high; FIFO empties, pointers go to 0.
//   Handshake
//     - req_ready = !reset && !flush && (count < DEPTH).
//     - A request is accepted on any edge where req_valid && req_ready.
//   Acceptance
//     - A request with req_rd==0 && !req_ovf is accepted and dropped; count is unchanged.
//     - Any other request is enqueued as {rd, data, ovf}, including ovf=1 with rd=0.
//   Drain
//     - On an edge where wb_en && count>0, the head entry is popped into the registered outputs rw/wd/addi_overflow, and regwrite is set to 1.
//     - Otherwise regwrite and addi_overflow are set to 0; rw and wd hold their last value.
//     - Because outputs are registered, regwrite is high for exactly one cycle per entry.
//     - Latency: request accepted at edge k into an empty FIFO with wb_en=1 -> regwrite high in the cycle after edge k+1.
//     - No same-cycle pass-through.
//   Simultaneous events
//     - Push and pop on the same edge leave count unchanged.
//     - At count==DEPTH no push is possible, even if a pop occurs on that edge.
//     - Pointers wrap modulo DEPTH.
//     - Order of writes is strictly FIFO.
//   Flush (synchronous)
//     - On the edge where flush is high, the FIFO empties (count=0) and regwrite/addi_overflow clear to 0.
//     - An output-stage write already presented during the flush cycle is completed by the GPR on that same edge.
//     - A push in the flush cycle is not accepted.
//     - reset dominates flush.
//   Hazard (combinational)
//     - A read port hits when its register number is nonzero and matches the effective target of any FIFO entry, or of the output stage while regwrite=1.
//     - Effective target = 30 when ovf=1, else rd.
//     - hazard = hit on chk_rs OR hit on chk_rt.
// CONFIGURATION
//   WB_FORWARD_EN defined
//     - fwd_x_hit equals that port's hazard term.
//     - fwd_x_data is the data of the youngest matching entry; the output stage is the oldest.
//     - For an ovf entry matched via reg 30, the forwarded data is 32'h1.
//   WB_FORWARD_EN undefined
//     - fwd_a_hit, fwd_b_hit, fwd_a_data and fwd_b_data are tied to 0.
//     - hazard is unchanged.
// TESTING
//   1. wb_en=1; push rd=5, data=32'hDEADBEEF -> regwrite=1, rw=5, wd=DEADBEEF for exactly one cycle, 2 edges after accept; count returns to 0.
//   2. Push rd=0, data=32'h1234, ovf=0 -> accepted (ready=1), count stays 0, regwrite never asserts.
//   3. wb_en=0; push rd=8, ovf=1; set chk_rs=30 -> hazard=1 while pending.
//      Then set wb_en=1 -> regwrite=1, addi_overflow=1, rw=8 in the same cycle; hazard=0 one cycle later.
//   4. wb_en=0; push 5 requests rd=1..5 -> req_ready=0 after the 4th, count=4.
//      Then set wb_en=1 -> writes rd=1,2,3,4 on consecutive cycles, 5th accepted once count<4, written after rd=4.
//   5. 3 entries pending, wb_en=0; flush=1 for one cycle -> count=0 on the next cycle, no regwrite afterwards, hazard=0.
//   6. wb_en=0; push rd=7, data=1, then rd=7, data=2; chk_rs=7 -> hazard=1.
//      With WB_FORWARD_EN: fwd_a_hit=1, fwd_a_data=2. Without: fwd_a_hit=0, fwd_a_data=0.

Source files
------------

// File: rtl/gpr_wb_queue.sv
// rtl/gpr_wb_queue.sv - in-order writeback queue driving the GPR write port, with pending-write hazard detection
// Optional feature macro: WB_FORWARD_EN (forward youngest pending data on the decode read ports)
module gpr_wb_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_data,
    input  logic             req_ovf,
    input  logic             wb_en,
    input  logic             flush,
    output logic [4:0]       rw,
    output logic [31:0]      wd,
    output logic             regwrite,
    output logic             addi_overflow,
    input  logic [4:0]       chk_rs,
    input  logic [4:0]       chk_rt,
    output logic             hazard,
    output logic             fwd_a_hit,
    output logic [31:0]      fwd_a_data,
    output logic             fwd_b_hit,
    output logic [31:0]      fwd_b_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ovf;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        rw_q;
    logic [31:0]       wd_q;
    logic              regwrite_q, ovf_q;
    logic              accept, push, pop;
    logic              hit_a, hit_b;

    // An overflowing addi writes 1 into r30 regardless of its nominal rd.
    function automatic logic [4:0] eff_tgt(input logic ovf, input logic [4:0] rd);
        return ovf ? 5'd30 : rd;
    endfunction

    assign req_ready = !reset && !flush && (count_q < CNT_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = accept && ((req_rd != 5'd0) || req_ovf);
    assign pop       = wb_en && (count_q != '0) && !flush;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rw_q       <= '0;
            wd_q       <= '0;
            regwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{rd: req_rd, data: req_data, ovf: req_ovf};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rw_q       <= mem_q[rd_ptr_q].rd;
                wd_q       <= mem_q[rd_ptr_q].data;
                ovf_q      <= mem_q[rd_ptr_q].ovf;
                regwrite_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_q + 1'b1;
            end else begin
                regwrite_q <= 1'b0;
                ovf_q      <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        if (regwrite_q) begin
            if (chk_rs != 5'd0 && eff_tgt(ovf_q, rw_q) == chk_rs) hit_a = 1'b1;
            if (chk_rt != 5'd0 && eff_tgt(ovf_q, rw_q) == chk_rt) hit_b = 1'b1;
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) < count_q) begin
                if (chk_rs != 5'd0 &&
                    eff_tgt(mem_q[rd_ptr_q + PTR_W'(j)].ovf, mem_q[rd_ptr_q + PTR_W'(j)].rd) == chk_rs)
                    hit_a = 1'b1;
                if (chk_rt != 5'd0 &&
                    eff_tgt(mem_q[rd_ptr_q + PTR_W'(j)].ovf, mem_q[rd_ptr_q + PTR_W'(j)].rd) == chk_rt)
                    hit_b = 1'b1;
            end
        end
    end

    assign hazard        = !reset && (hit_a || hit_b);
    assign rw            = rw_q;
    assign wd            = wd_q;
    assign regwrite      = regwrite_q;
    assign addi_overflow = ovf_q;
    assign count         = count_q;

`ifdef WB_FORWARD_EN
    logic [31:0] fwd_a_d, fwd_b_d;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (regwrite_q) begin
            if (chk_rs != 5'd0 && eff_tgt(ovf_q, rw_q) == chk_rs) fwd_a_d = ovf_q ? 32'h1 : wd_q;
            if (chk_rt != 5'd0 && eff_tgt(ovf_q, rw_q) == chk_rt) fwd_b_d = ovf_q ? 32'h1 : wd_q;
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) < count_q) begin
                if (chk_rs != 5'd0 &&
                    eff_tgt(mem_q[rd_ptr_q + PTR_W'(j)].ovf, mem_q[rd_ptr_q + PTR_W'(j)].rd) == chk_rs)
                    fwd_a_d = mem_q[rd_ptr_q + PTR_W'(j)].ovf ? 32'h1 : mem_q[rd_ptr_q + PTR_W'(j)].data;
                if (chk_rt != 5'd0 &&
                    eff_tgt(mem_q[rd_ptr_q + PTR_W'(j)].ovf, mem_q[rd_ptr_q + PTR_W'(j)].rd) == chk_rt)
                    fwd_b_d = mem_q[rd_ptr_q + PTR_W'(j)].ovf ? 32'h1 : mem_q[rd_ptr_q + PTR_W'(j)].data;
            end
        end
    end

    assign fwd_a_hit  = !reset && hit_a;
    assign fwd_b_hit  = !reset && hit_b;
    assign fwd_a_data = reset ? 32'h0 : fwd_a_d;
    assign fwd_b_data = reset ? 32'h0 : fwd_b_d;
`else
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = 32'h0;
    assign fwd_b_data = 32'h0;
`endif

endmodule

// File: tb/tb_gpr_wb_queue.sv
// tb/tb_gpr_wb_queue.sv - directed-vector bench for gpr_wb_queue
module tb_gpr_wb_queue;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ovf, wb_en, flush;
    logic [4:0]  req_rd, chk_rs, chk_rt, rw;
    logic [31:0] req_data, wd, fwd_a_data, fwd_b_data;
    logic        req_ready, regwrite, addi_overflow, hazard, fwd_a_hit, fwd_b_hit;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    gpr_wb_queue dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_data(req_data), .req_ovf(req_ovf),
        .wb_en(wb_en), .flush(flush),
        .rw(rw), .wd(wd), .regwrite(regwrite), .addi_overflow(addi_overflow),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .hazard(hazard),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance across one rising edge and settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input logic [4:0] rd, input logic [31:0] data, input logic ovf);
        req_valid = 1'b1; req_rd = rd; req_data = data; req_ovf = ovf;
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_ovf = 1'b0; wb_en = 1'b0; flush = 1'b0;
        req_rd = '0; req_data = '0; chk_rs = '0; chk_rt = '0;
        tick(); tick();
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_count", count, 0);
        check("rst_hazard", hazard, 0);
        check("rst_rw_wd", {rw, wd[26:0]}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);

        // Single write: two edges from accept to regwrite.
        wb_en = 1'b1;
        push_one(5'd5, 32'hDEADBEEF, 1'b0);
        check("t1_count_k", count, 1);
        check("t1_rw_early", regwrite, 0);
        tick(); #1;
        check("t1_regwrite", regwrite, 1);
        check("t1_rw", rw, 5);
        check("t1_wd", wd, 32'hDEADBEEF);
        check("t1_count0", count, 0);
        tick(); #1;
        check("t1_pulse_end", regwrite, 0);
        check("t1_wd_hold", wd, 32'hDEADBEEF);

        // r0 write without overflow is swallowed.
        req_valid = 1'b1; req_rd = 5'd0; req_data = 32'h1234; req_ovf = 1'b0;
        #1;
        check("t2_ready", req_ready, 1);
        tick(); req_valid = 1'b0; #1;
        check("t2_count", count, 0);
        tick(); #1;
        check("t2_no_write", regwrite, 0);

        // Overflow entry targets r30, not its rd.
        wb_en = 1'b0;
        push_one(5'd8, 32'h55, 1'b1);
        chk_rs = 5'd8; #1;
        check("t3_rd8_nohit", hazard, 0);
        chk_rs = 5'd30; #1;
        check("t3_hazard30", hazard, 1);
        check("t3_fwd_hit", fwd_a_hit, FWD);
        check("t3_fwd_data", fwd_a_data, FWD ? 32'h1 : 32'h0);
        wb_en = 1'b1;
        tick(); #1;
        check("t3_regwrite", regwrite, 1);
        check("t3_ovf", addi_overflow, 1);
        check("t3_rw", rw, 8);
        check("t3_hazard_stage", hazard, 1);
        tick(); #1;
        check("t3_hazard_clear", hazard, 0);
        check("t3_ovf_clear", addi_overflow, 0);
        chk_rs = 5'd0;

        // Fill to DEPTH, then drain with a blocked fifth request.
        wb_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            req_valid = 1'b1; req_rd = 5'(i); req_data = 32'(100 + i); req_ovf = 1'b0;
            #1;
            check($sformatf("t4_ready_%0d", i), req_ready, (i <= 4) ? 1 : 0);
            if (i <= 4) tick();
        end
        check("t4_full_count", count, 4);
        wb_en = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            automatic logic acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
            #1;
            check($sformatf("t4_we_%0d", c), regwrite, 1);
            check($sformatf("t4_rw_%0d", c), rw, 5'(c));
            check($sformatf("t4_wd_%0d", c), wd, 32'(100 + c));
        end
        check("t4_valid_taken", req_valid, 0);
        tick(); #1;
        check("t4_done", regwrite, 0);
        check("t4_count0", count, 0);

        // Flush with three pending; push in flush cycle is refused.
        wb_en = 1'b0;
        push_one(5'd9, 32'h9, 1'b0);
        push_one(5'd10, 32'hA, 1'b0);
        push_one(5'd11, 32'hB, 1'b0);
        check("t5_count3", count, 3);
        chk_rs = 5'd10; #1;
        check("t5_hazard_pre", hazard, 1);
        flush = 1'b1; req_valid = 1'b1; req_rd = 5'd12; #1;
        check("t5_ready_flush", req_ready, 0);
        tick(); flush = 1'b0; req_valid = 1'b0; #1;
        check("t5_count0", count, 0);
        check("t5_hazard_post", hazard, 0);
        wb_en = 1'b1;
        tick(); #1;
        check("t5_no_write1", regwrite, 0);
        tick(); #1;
        check("t5_no_write2", regwrite, 0);
        chk_rs = 5'd0;

        // Youngest match forwards.
        wb_en = 1'b0;
        push_one(5'd7, 32'h1, 1'b0);
        push_one(5'd7, 32'h2, 1'b0);
        chk_rs = 5'd7; chk_rt = 5'd0; #1;
        check("t6_hazard", hazard, 1);
        check("t6_fwd_a_hit", fwd_a_hit, FWD);
        check("t6_fwd_a_data", fwd_a_data, FWD ? 32'h2 : 32'h0);
        check("t6_fwd_b_hit", fwd_b_hit, 0);
        chk_rs = 5'd0; chk_rt = 5'd7; #1;
        check("t6_fwd_b_data", fwd_b_data, FWD ? 32'h2 : 32'h0);
        chk_rt = 5'd0; #1;
        check("t6_r0_nohit", hazard, 0);

        // Reset with entries pending.
        reset = 1'b1; #1;
        check("t7_ready_in_rst", req_ready, 0);
        tick(); #1;
        check("t7_count_rst", count, 0);
        reset = 1'b0; wb_en = 1'b1;
        tick(); #1;
        check("t7_no_write", regwrite, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
